// File: rtl/kgp_bitarr_pkg.sv
// Shared types and helpers for the bit-array memory-image writer.
package kgp_bitarr_pkg;
    typedef enum logic [1:0] {IDLE, WR_N, WR_BIT, FIN} state_t;

    localparam int WORD_BYTES = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/bit_array_writer_msb_index_finder.sv
// Priority encoder: position of the most significant 1 plus 1; returns 1 for an all-zero input.
module msb_index_finder
    import kgp_bitarr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CW     = clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] value,
    output logic [CW-1:0]     n
);
    always_comb begin
        n = CW'(1);
        for (int i = 0; i < DATA_W; i++) begin
            if (value[i]) n = CW'(i + 1);
        end
    end
endmodule

// File: rtl/bit_array_writer.sv
// Writes n then the binary digits of value (MSB first), one per word, starting at base_addr.
// Define BIT_ARRAY_LZ_SUPPRESS_EN to drop leading zeros; otherwise n = DATA_W.
module bit_array_writer
    import kgp_bitarr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready
);
    localparam int CW = clog2(DATA_W) + 1;

    state_t            state, state_nx;
    logic [DATA_W-1:0] sr;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     n_q, cnt_q, n_calc;
    logic              accept;

`ifdef BIT_ARRAY_LZ_SUPPRESS_EN
    msb_index_finder #(.DATA_W(DATA_W), .CW(CW)) u_msb (
        .value (value),
        .n     (n_calc)
    );
`else
    assign n_calc = CW'(DATA_W);
`endif

    // Outputs decode from state only, so mem_ready never reaches mem_wr_en combinationally.
    always_comb begin
        mem_wr_en = (state == WR_N) || (state == WR_BIT);
        busy      = mem_wr_en;
        done      = (state == FIN);
        mem_addr  = mem_wr_en ? addr_q : '0;
        mem_wdata = '0;
        case (state)
            WR_N:    mem_wdata = 32'(n_q);
            WR_BIT:  mem_wdata = {31'b0, sr[DATA_W-1]};
            default: mem_wdata = '0;
        endcase
    end

    assign accept = mem_wr_en && mem_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WR_N;
            WR_N:    if (mem_ready) state_nx = WR_BIT;
            WR_BIT:  if (mem_ready && cnt_q == CW'(1)) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            addr_q <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr_q <= base_addr;
                n_q    <= n_calc;
                cnt_q  <= n_calc;
                // Align digit n-1 to the top so every write takes the MSB.
                sr     <= value << (CW'(DATA_W) - n_calc);
            end else if (accept) begin
                addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                if (state == WR_BIT) begin
                    sr    <= {sr[DATA_W-2:0], 1'b0};
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_array_writer.sv
// Directed vector bench for bit_array_writer; n expectations follow BIT_ARRAY_LZ_SUPPRESS_EN.
module tb_bit_array_writer;
    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [31:0] value, base_addr;
    logic        busy, done, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] wr_data [0:63];

    bit_array_writer #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [31:0] base;
        int          n_off;
        int          n_on;
        int          stall_k;
        int          stall_len;
        bit          poke_start;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"},  {31'b0, busy},      32'd0);
        chk({nm, "_done"},  {31'b0, done},      32'd0);
        chk({nm, "_wr_en"}, {31'b0, mem_wr_en}, 32'd0);
        chk({nm, "_addr"},  mem_addr,           32'd0);
        chk({nm, "_wdata"}, mem_wdata,          32'd0);
    endtask

    // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run(input vec_t v, input int expn, input string nm);
        int k, cyc, stall_left;
        bit seen;
        logic [31:0] ea, ed;
        value = v.value; base_addr = v.base; start = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; value = ~v.value; base_addr = v.base + 32'h40;
        k = 0; cyc = 0; stall_left = v.stall_len; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            start = (v.poke_start && cyc == 2);
            if (done) begin
                seen = 1'b1;
                chk($sformatf("%s_done_cycle", nm), cyc, expn + 2 + v.stall_len);
                chk($sformatf("%s_write_count", nm), k, expn + 1);
                chk($sformatf("%s_busy_in_fin", nm), {31'b0, busy}, 32'd0);
            end else begin
                ea = v.base + 32'(4 * k);
                ed = (k == 0) ? 32'(expn) : {31'b0, v.value[expn - k]};
                chk($sformatf("%s_wr_en_%0d", nm, k), {31'b0, mem_wr_en}, 32'd1);
                chk($sformatf("%s_addr_%0d", nm, k), mem_addr, ea);
                chk($sformatf("%s_data_%0d", nm, k), mem_wdata, ed);
                if (k == v.stall_k && stall_left > 0) begin
                    mem_ready = 1'b0; stall_left--;
                end else begin
                    mem_ready = 1'b1;
                    if (k < 64) wr_data[k] = mem_wdata;
                    k++;
                end
            end
        end
        start = 1'b0;
        if (!seen) chk($sformatf("%s_timeout", nm), 32'd1, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk($sformatf("%s_post_done", nm), {31'b0, done}, 32'd0);
            chk($sformatf("%s_post_wr_en", nm), {31'b0, mem_wr_en}, 32'd0);
        end
    endtask

    function automatic int pick_n(input vec_t v);
`ifdef BIT_ARRAY_LZ_SUPPRESS_EN
        return v.n_on;
`else
        return v.n_off;
`endif
    endfunction

    vec_t vecs [0:5];
    vec_t fresh;

    initial begin
        int n;
        vecs[0] = '{32'd13,        32'h0000_0000, 32, 4,  -1, 0, 1'b0};
        vecs[1] = '{32'd13,        32'h0000_0100, 32, 4,   1, 3, 1'b0};
        vecs[2] = '{32'd0,         32'h0000_0200, 32, 1,  -1, 0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0300, 32, 32, -1, 0, 1'b0};
        vecs[4] = '{32'h0000_002D, 32'hFFFF_FFF0, 32, 6,  -1, 0, 1'b1};
        vecs[5] = '{32'hA5A5_A5A5, 32'h0000_0040, 32, 32,  0, 2, 1'b1};
        fresh   = '{32'h0000_002D, 32'h0000_0600, 32, 6,  -1, 0, 1'b0};

        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; value = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk_idle("idle_ready_ignored");

        for (int i = 0; i < 6; i++) begin
            n = pick_n(vecs[i]);
            run(vecs[i], n, $sformatf("vec%0d", i));
            if (i == 0) begin
                // Value 13 = 1101: the last four digits and the n word are fixed.
                chk("v13_n_word", wr_data[0],     32'(n));
                chk("v13_d3",     wr_data[n - 3], 32'd1);
                chk("v13_d2",     wr_data[n - 2], 32'd1);
                chk("v13_d1",     wr_data[n - 1], 32'd0);
                chk("v13_d0",     wr_data[n],     32'd1);
            end
        end

        // rst and start together: rst wins, nothing latched.
        rst = 1'b1; start = 1'b1; value = 32'd7; base_addr = 32'h700;
        @(negedge clk);
        chk_idle("rst_start_same_edge");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_idle("rst_start_after");

        // Reset in the middle of the digit writes.
        value = 32'hA5A5_A5A5; base_addr = 32'h500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midop_in_wr_bit", {31'b0, mem_wr_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("midop_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midop_after_rst");

        run(fresh, pick_n(fresh), "fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
